// File: rtl/fp_multiply_seq.sv
// Sequential IEEE-754 multiplier: radix-2 shift-add mantissa datapath, start/ready handshake.
// Define FMUL_RNE_EN to round to nearest-even in NORM; the default build truncates.
module fp_multiply_seq #(
  parameter int X = 32
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         start,
  input  logic [X-1:0] A,
  input  logic [X-1:0] B,
  output logic [X-1:0] out,
  output logic         ready,
  output logic         busy,
  output logic         overflow,
  output logic         underflow
);

  localparam int EB   = (X == 64) ? 11 : 8;
  localparam int MB   = (X == 64) ? 52 : 23;
  localparam int BIAS = (1 << (EB - 1)) - 1;
  localparam int EW   = EB + 2;
  localparam int PW   = 2 * (MB + 1);
  localparam int CW   = $clog2(MB + 2);

  localparam logic signed [EW-1:0] BIAS_E   = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EB) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        p_q, p_d;
  logic [MB:0]          ma_q, ma_d, mb_q, mb_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic                 sign_q, sign_d, zero_q, zero_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [X-1:0]         out_q, out_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d, busy_q, busy_d;

  logic                 top;
  logic [MB-1:0]        man_n;
  logic signed [EW-1:0] exp_n;
  logic [MB+1:0]        sum;
`ifdef FMUL_RNE_EN
  logic [MB-1:0]        kept;
  logic [MB:0]          rnd;
  logic                 guard, sticky;
`endif

  // Partial-product add into the upper half of P; bit MB+1 is the carry.
  always_comb begin
    sum = {1'b0, p_q[PW-1:MB+1]} + {1'b0, (mb_q[0] ? ma_q : '0)};
  end

  // NOTE: every variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    top   = p_q[PW-1];
    exp_n = exp_q + {{(EW-1){1'b0}}, top};
`ifdef FMUL_RNE_EN
    if (top) begin
      kept   = p_q[2*MB:MB+1];
      guard  = p_q[MB];
      sticky = |p_q[MB-1:0];
    end else begin
      kept   = p_q[2*MB-1:MB];
      guard  = p_q[MB-1];
      sticky = |p_q[MB-2:0];
    end
    rnd   = {1'b0, kept} + {{MB{1'b0}}, guard & (sticky | kept[0])};
    // A carry out of the mantissa leaves it all-zero and bumps the exponent.
    man_n = rnd[MB-1:0];
    exp_n = exp_n + {{(EW-1){1'b0}}, rnd[MB]};
`else
    man_n = top ? p_q[2*MB:MB+1] : p_q[2*MB-1:MB];
`endif
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          sign_d  = A[X-1] ^ B[X-1];
          exp_d   = $signed({2'b00, A[X-2:MB]}) + $signed({2'b00, B[X-2:MB]}) - BIAS_E;
          zero_d  = (A[X-2:MB] == '0) || (B[X-2:MB] == '0);
          ma_d    = {1'b1, A[MB-1:0]};
          mb_d    = {1'b1, B[MB-1:0]};
          p_d     = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        // After the last multiplier bit one more MUL cycle elapses before NORM,
        // which places the ready pulse mant_bits+3 edges after acceptance.
        if (cnt_q == CW'(MB + 1)) begin
          state_d = NORM;
        end else begin
          p_d   = PW'({sum, p_q[MB:0]} >> 1);
          mb_d  = mb_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      NORM: begin
        busy_d  = 1'b0;
        state_d = DONE;
        if (zero_q) begin
          out_d = {sign_q, {(X-1){1'b0}}};
        end else if (exp_n >= EXP_MAX) begin
          ovf_d = 1'b1;
          out_d = {sign_q, {EB{1'b1}}, {MB{1'b0}}};
        end else if (exp_n <= EXP_ZERO) begin
          unf_d = 1'b1;
          out_d = {sign_q, {(X-1){1'b0}}};
        end else begin
          out_d = {sign_q, exp_n[EB-1:0], man_n};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      // NOTE: datapath registers are reset as well, so an abandoned operation leaves no residue.
      state_q <= IDLE;
      p_q     <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      busy_q  <= busy_d;
    end
  end

  assign out       = out_q;
  assign ready     = (state_q == DONE);
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/fp_multiply_seq.md
Name: fp_multiply_seq

Overview:
- Sequential IEEE-754 multiplier; the inverse-operation companion to the floating-point divider in the FPU.
- Operands are accepted on a start pulse and multiplied with an iterative radix-2 shift-add mantissa datapath.
- The result is normalized, with overflow and underflow flags.
- Result is presented with a one-cycle ready pulse, under the same start/ready handshake the FPU datapath uses for division.

Parameters:
- X, 32, operand width; 32 = single (8-bit exponent, 23-bit mantissa, bias 127), 64 = double (11, 52, 1023). Other values unsupported.

Ports:
- clk  input  1  clock, rising edge.
- clrn  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only while busy=0.
- A  input  X  multiplicand, IEEE format.
- B  input  X  multiplier, IEEE format.
- out  output  X  product; held stable from the ready pulse until the next ready pulse.
- ready  output  1  one-cycle pulse: out/overflow/underflow valid.
- busy  output  1  high from the edge accepting start until the edge entering DONE.
- overflow  output  1  result exponent saturated; valid with ready.
- underflow  output  1  result flushed to zero; valid with ready.

Behaviour:
- Reset:
  - clrn=0 at a rising edge forces state IDLE.
  - out, ready, busy, overflow and underflow all go to 0.
  - Internal accumulator and counter are cleared.
  - Reset mid-operation abandons the operation; no ready pulse follows.
- States: IDLE, MUL, NORM, DONE.
- IDLE:
  - On start=1, latch A and B.
  - sign = A[X-1]^B[X-1].
  - Exponent sum = ea+eb-bias, computed in expo_bits+2 signed bits.
  - Load multiplier {1,mant_b}, clear the 2*(mant_bits+1)-bit accumulator P, counter=0.
  - Clear overflow/underflow, set busy=1, go to MUL.
- Zero operand: if either exponent field is 0, the operand is treated as zero (denormals flushed). The operation still runs full latency and yields {sign, all-zero}, with flags 0.
- MUL:
  - One multiplier bit per cycle, LSB first. Add {1,mant_a} to the upper half of P if the bit is 1, then shift P right by one, capturing the carry.
  - Runs exactly mant_bits+1 cycles, then goes to NORM.
- NORM (single cycle):
  - If P[2*mant_bits+1]=1: exponent+1, mantissa = P[2*mant_bits:mant_bits+1].
  - Otherwise: mantissa = P[2*mant_bits-1:mant_bits].
  - Default rounding is truncation.
  - If biased exponent >= 2^expo_bits-1: overflow=1, out = {sign, all-ones exponent, zero mantissa}.
  - If biased exponent <= 0: underflow=1, out = {sign, zeros}.
  - Otherwise out = {sign, exp, mantissa}.
  - Set busy=0, go to DONE.
- DONE:
  - ready=1 for this cycle only.
  - Next state is IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation.
- Latency: ready is high in the cycle following the (mant_bits+3)th rising edge after the accepting edge. That is 26 edges for X=32 and 55 for X=64.
- start while busy=1 is ignored; A and B may change freely after acceptance.
- Inf/NaN inputs are not detected; they are processed as ordinary numbers.

Optional Feature:
- Macro: FMUL_RNE_EN.
- Defined: NORM applies round-to-nearest-even.
  - Guard bit = bit below the kept LSB; sticky = OR of the remaining lower P bits.
  - Increment when guard & (sticky | lsb).
  - A mantissa carry-out increments the exponent and clears the mantissa, before the overflow check.
  - Latency is unchanged.
- Undefined: truncation only; no rounding logic synthesized.

Test Plan:
- A=0x40000000, B=0x40400000, start 1 cycle -> ready exactly 26 edges later, out=0x40C00000, flags 0, busy high throughout.
- A=0x3FC00000, B=0x3FC00000 -> out=0x40100000 (normalize-up path); A=0xC0000000, B=0x3F000000 -> out=0xBF800000.
- A=0x7F000000, B=0x7F000000 -> overflow=1, out=0x7F800000. A=0x00800000, B=0x00800000 -> underflow=1, out=0x00000000. A=0x80000000, B=0x40400000 -> out=0x80000000, flags 0.
- A=0x3F800005, B=0x3FC00000 -> without FMUL_RNE_EN out=0x3FC00007; with it out=0x3FC00008 (tie to even).
- Start during MUL with other operands -> ignored, first result unchanged. Start asserted in the DONE cycle -> second result 26 edges later.
- clrn=0 for one cycle at MUL cycle 10 -> all outputs 0, state IDLE, no ready. The next start completes normally.
